reservation_station_mc: RTL

//  Multi-entry, age-ordered reservation station with NUM_CDB parallel wakeup (CDB) channels.

---
 rtl/reservation_station_mc.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/reservation_station_mc.sv
// reservation_station_mc: age-ordered reservation station with NUM_CDB parallel
// wakeup channels, placed between the dispatcher and one functional unit.
//   clk, reset (async, active-high)
//   load/func/t1/t2/dst/ready1/ready2/v1/v2/pc/imm : dispatch of one renamed insn
//   cdb_valid/cdb_tag/cdb_value : NUM_CDB packed wakeup channels, channel 0 in LSBs
//   issue       : grant from the issue unit, honoured only while insn_ready
//   insn_ready  : some entry is ready this cycle (includes same-cycle CDB bypass)
//   is_full, free_count : occupancy, decoded from registered valid bits
//   dst_tag     : destination tag of the entry selected for issue, 0 if none
//   start, func_out, v1_out, v2_out, pc_out, imm_out : registered issue payload
// Optional feature: define RS_FLUSH_EN to add a `flush` input that empties the
// station on the edge (payload registers hold, start forced low).

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

module reservation_station_mc #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned NUM_CDB     = 2,
    parameter int unsigned TAG_W       = `ROB_TAG_LEN,
    parameter int unsigned XLEN        = `XLEN,
    parameter int unsigned FUNC_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef RS_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         load,
    input  logic [FUNC_W-1:0]            func,
    input  logic [TAG_W-1:0]             t1,
    input  logic [TAG_W-1:0]             t2,
    input  logic [TAG_W-1:0]             dst,
    input  logic                         ready1,
    input  logic                         ready2,
    input  logic [XLEN-1:0]              v1,
    input  logic [XLEN-1:0]              v2,
    input  logic [XLEN-1:0]              pc,
    input  logic [XLEN-1:0]              imm,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_value,
    input  logic                         issue,
    output logic                         insn_ready,
    output logic                         is_full,
    output logic [$clog2(NUM_ENTRIES):0] free_count,
    output logic [TAG_W-1:0]             dst_tag,
    output logic                         start,
    output logic [FUNC_W-1:0]            func_out,
    output logic [XLEN-1:0]              v1_out,
    output logic [XLEN-1:0]              v2_out,
    output logic [XLEN-1:0]              pc_out,
    output logic [XLEN-1:0]              imm_out
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [FUNC_W-1:0] ALU_ADD = '0;

    // Entry storage
    logic [NUM_ENTRIES-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [FUNC_W-1:0]      func_q [NUM_ENTRIES];
    logic [FUNC_W-1:0]      func_d [NUM_ENTRIES];
    logic [TAG_W-1:0]       t1_q   [NUM_ENTRIES];
    logic [TAG_W-1:0]       t1_d   [NUM_ENTRIES];
    logic [TAG_W-1:0]       t2_q   [NUM_ENTRIES];
    logic [TAG_W-1:0]       t2_d   [NUM_ENTRIES];
    logic [TAG_W-1:0]       dst_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]       dst_d  [NUM_ENTRIES];
    logic [XLEN-1:0]        v1_q   [NUM_ENTRIES];
    logic [XLEN-1:0]        v1_d   [NUM_ENTRIES];
    logic [XLEN-1:0]        v2_q   [NUM_ENTRIES];
    logic [XLEN-1:0]        v2_d   [NUM_ENTRIES];
    logic [XLEN-1:0]        pc_q   [NUM_ENTRIES];
    logic [XLEN-1:0]        pc_d   [NUM_ENTRIES];
    logic [XLEN-1:0]        imm_q  [NUM_ENTRIES];
    logic [XLEN-1:0]        imm_d  [NUM_ENTRIES];
    logic [IDX_W-1:0]       age_q  [NUM_ENTRIES];
    logic [IDX_W-1:0]       age_d  [NUM_ENTRIES];

    // Issue payload registers
    logic              start_q, start_d;
    logic [FUNC_W-1:0] func_out_q, func_out_d;
    logic [XLEN-1:0]   v1_out_q, v1_out_d, v2_out_q, v2_out_d;
    logic [XLEN-1:0]   pc_out_q, pc_out_d, imm_out_q, imm_out_d;

    // Combinational helpers
    logic [NUM_ENTRIES-1:0] hit1_c, hit2_c, entry_rdy_c;
    logic [XLEN-1:0]        op1_c [NUM_ENTRIES];
    logic [XLEN-1:0]        op2_c [NUM_ENTRIES];
    logic                   ld_hit1_c, ld_hit2_c;
    logic [XLEN-1:0]        ld_op1_c, ld_op2_c;
    logic                   sel_found_c, free_found_c;
    logic [IDX_W-1:0]       sel_idx_c, sel_age_c, free_idx_c;
    logic [CNT_W-1:0]       valid_cnt_c;
    logic                   flush_c, do_issue_c, do_load_c;

`ifdef RS_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // {hit, value} for a tag across all channels; lowest channel wins on duplicates
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  vals
    );
        logic [XLEN:0] r;
        r = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!r[XLEN] && vld[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
                r = {1'b1, vals[k*XLEN +: XLEN]};
            end
        end
        return r;
    endfunction

    // CDB snoop for stored entries and for the insn being dispatched
    always_comb begin : snoop
        logic [XLEN:0] lk;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            lk        = cdb_lookup(t1_q[i], cdb_valid, cdb_tag, cdb_value);
            hit1_c[i] = lk[XLEN];
            op1_c[i]  = lk[XLEN] ? lk[XLEN-1:0] : v1_q[i];
            lk        = cdb_lookup(t2_q[i], cdb_valid, cdb_tag, cdb_value);
            hit2_c[i] = lk[XLEN];
            op2_c[i]  = lk[XLEN] ? lk[XLEN-1:0] : v2_q[i];
            entry_rdy_c[i] = valid_q[i] && (rdy1_q[i] || hit1_c[i]) && (rdy2_q[i] || hit2_c[i]);
        end
        lk        = cdb_lookup(t1, cdb_valid, cdb_tag, cdb_value);
        ld_hit1_c = lk[XLEN];
        ld_op1_c  = lk[XLEN] ? lk[XLEN-1:0] : v1;
        lk        = cdb_lookup(t2, cdb_valid, cdb_tag, cdb_value);
        ld_hit2_c = lk[XLEN];
        ld_op2_c  = lk[XLEN] ? lk[XLEN-1:0] : v2;
    end

    // Oldest ready entry, lowest free slot and occupancy
    always_comb begin
        sel_found_c  = 1'b0;
        sel_idx_c    = '0;
        sel_age_c    = '0;
        free_found_c = 1'b0;
        free_idx_c   = '0;
        valid_cnt_c  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entry_rdy_c[i] && (!sel_found_c || (age_q[i] < sel_age_c))) begin
                sel_found_c = 1'b1;
                sel_idx_c   = IDX_W'(i);
                sel_age_c   = age_q[i];
            end
            if (!valid_q[i] && !free_found_c) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
            valid_cnt_c = valid_cnt_c + CNT_W'(valid_q[i]);
        end
    end

    assign insn_ready = sel_found_c;
    assign is_full    = &valid_q;
    assign free_count = CNT_W'(NUM_ENTRIES) - valid_cnt_c;
    assign dst_tag    = sel_found_c ? dst_q[sel_idx_c] : '0;

    assign do_issue_c = issue && sel_found_c && !flush_c;
    assign do_load_c  = load && !is_full && !flush_c;

    // Next-state: wakeup, issue (with age compaction), dispatch, flush
    always_comb begin
        valid_d    = valid_q;
        rdy1_d     = rdy1_q | hit1_c;
        rdy2_d     = rdy2_q | hit2_c;
        func_d     = func_q;
        t1_d       = t1_q;
        t2_d       = t2_q;
        dst_d      = dst_q;
        v1_d       = op1_c;
        v2_d       = op2_c;
        pc_d       = pc_q;
        imm_d      = imm_q;
        age_d      = age_q;
        start_d    = do_issue_c;
        func_out_d = func_out_q;
        v1_out_d   = v1_out_q;
        v2_out_d   = v2_out_q;
        pc_out_d   = pc_out_q;
        imm_out_d  = imm_out_q;

        if (do_issue_c) begin
            valid_d[sel_idx_c] = 1'b0;
            func_out_d = func_q[sel_idx_c];
            v1_out_d   = op1_c[sel_idx_c];
            v2_out_d   = op2_c[sel_idx_c];
            pc_out_d   = pc_q[sel_idx_c];
            imm_out_d  = imm_q[sel_idx_c];
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (valid_q[i] && (age_q[i] > sel_age_c)) begin
                    age_d[i] = age_q[i] - IDX_W'(1);
                end
            end
        end

        if (do_load_c) begin
            valid_d[free_idx_c] = 1'b1;
            rdy1_d[free_idx_c]  = ready1 || ld_hit1_c;
            rdy2_d[free_idx_c]  = ready2 || ld_hit2_c;
            func_d[free_idx_c]  = func;
            t1_d[free_idx_c]    = t1;
            t2_d[free_idx_c]    = t2;
            dst_d[free_idx_c]   = dst;
            v1_d[free_idx_c]    = ld_op1_c;
            v2_d[free_idx_c]    = ld_op2_c;
            pc_d[free_idx_c]    = pc;
            imm_d[free_idx_c]   = imm;
            // The issued entry vacates one age slot this same edge
            age_d[free_idx_c]   = IDX_W'(valid_cnt_c - CNT_W'(do_issue_c));
        end

        if (flush_c) begin
            valid_d = '0;
            for (int i = 0; i < NUM_ENTRIES; i++) age_d[i] = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                func_q[i] <= ALU_ADD;
                t1_q[i]   <= '0;
                t2_q[i]   <= '0;
                dst_q[i]  <= '0;
                v1_q[i]   <= '0;
                v2_q[i]   <= '0;
                pc_q[i]   <= '0;
                imm_q[i]  <= '0;
                age_q[i]  <= '0;
            end
            start_q    <= 1'b0;
            func_out_q <= ALU_ADD;
            v1_out_q   <= '0;
            v2_out_q   <= '0;
            pc_out_q   <= '0;
            imm_out_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            rdy1_q     <= rdy1_d;
            rdy2_q     <= rdy2_d;
            func_q     <= func_d;
            t1_q       <= t1_d;
            t2_q       <= t2_d;
            dst_q      <= dst_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            age_q      <= age_d;
            start_q    <= start_d;
            func_out_q <= func_out_d;
            v1_out_q   <= v1_out_d;
            v2_out_q   <= v2_out_d;
            pc_out_q   <= pc_out_d;
            imm_out_q  <= imm_out_d;
        end
    end

    assign start    = start_q;
    assign func_out = func_out_q;
    assign v1_out   = v1_out_q;
    assign v2_out   = v2_out_q;
    assign pc_out   = pc_out_q;
    assign imm_out  = imm_out_q;

endmodule
